// File: rtl/add_nibble_seq.sv
// Purpose: multi-cycle WIDTH-bit add/sub that reuses one 4-bit ripple slice, LS nibble first.
// Latency: start sampled at edge 0, done pulses for the cycle after edge NIBBLES (NIBBLES+1 edges).
// Backpressure: none; start is ignored while busy, and accepted in IDLE or DONE (back-to-back).

// One-bit full adder used to build the shared nibble slice.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module add_nibble_seq #(
  parameter  int WIDTH   = 32,
  localparam int NIBBLES = WIDTH / 4,
  localparam int IW      = $clog2(NIBBLES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] opa, opb;
  logic             carry;
  logic [IW-1:0]    idx;
  logic [IW+1:0]    base;
  logic             last;
  logic             accept;

  logic [3:0]       na, nb, slice_sum;
  logic [4:0]       c;
  logic             slice_cout;

  // Bit offset of the nibble currently being processed.
  assign base = {idx, 2'b00};
  assign last = (idx == IW'(NIBBLES - 1));

  assign na   = opa[base +: 4];
  assign nb   = opb[base +: 4];
  assign c[0] = carry;

  genvar i;
  generate
    for (i = 0; i < 4; i++) begin : g_slice
      full_adder u_fa (
        .a   (na[i]),
        .b   (nb[i]),
        .cin (c[i]),
        .sum (slice_sum[i]),
        .cout(c[i+1])
      );
    end
  endgenerate

  assign slice_cout = c[4];

  // Status is decoded straight from the state register, so busy and done are exclusive.
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; a request is only honoured outside RUN.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture operands on accept, then fold one nibble per RUN cycle.
  // Subtraction is a + ~b + 1, so sub only shapes opb and the initial carry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opa      <= '0;
      opb      <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      s        <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      opa      <= a;
      opb      <= sub ? ~b : b;
      carry    <= sub;
      idx      <= '0;
      s        <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (state == RUN) begin
      s[base +: 4] <= slice_sum;
      carry        <= slice_cout;
      idx          <= idx + 1'b1;
      if (last) begin
        cout     <= slice_cout;
        overflow <= (opa[WIDTH-1] == opb[WIDTH-1]) && (slice_sum[3] != opa[WIDTH-1]);
      end
    end
  end

endmodule

// File: tb/tb_add_nibble_seq.sv
// Directed bench for add_nibble_seq: 32-bit and 8-bit instances, hand-computed results.
module tb_add_nibble_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, cout, overflow;
  logic [31:0] s;

  logic        start8 = 1'b0;
  logic        sub8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        busy8, done8, cout8, overflow8;
  logic [7:0]  s8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  add_nibble_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .s(s), .cout(cout), .overflow(overflow)
  );

  add_nibble_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .s(s8), .cout(cout8), .overflow(overflow8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One 32-bit operation from IDLE: checks latency, busy run length, result, and hold after done.
  task automatic op32(input string tag, input logic [31:0] aa, input logic [31:0] bb,
                      input logic sb, input logic [31:0] es, input logic ec, input logic eo);
    int n, nbusy;
    a = aa; b = bb; sub = sb; start = 1'b1;
    step();
    start = 1'b0;
    n = 0; nbusy = 0;
    while (!done && n < 20) begin
      if (busy) nbusy++;
      step();
      n++;
    end
    chk({tag, "_lat"}, n, 8);
    chk({tag, "_busy"}, nbusy, 8);
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_s"}, s, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"}, overflow, eo);
    step();
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_s_hold"}, s, es);
  endtask

  initial begin
    int n, ndone;

    // Reset state, observed before any clock edge.
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_s", s, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", overflow, 0);
    @(negedge clk);
    reset = 1'b0;
    step();

    op32("wrap",   32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);
    op32("posovf", 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
    op32("negovf", 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1);
    op32("sub57",  32'd5,        32'd7,        1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    op32("sub75",  32'd7,        32'd5,        1'b1, 32'h00000002, 1'b1, 1'b0);

    // Start held high and operands scrambled during RUN: only latched values count.
    a = 32'h12345678; b = 32'h11111111; sub = 1'b0; start = 1'b1;
    step();
    n = 0;
    while (!done && n < 20) begin
      a = $urandom; b = $urandom; sub = $urandom_range(0, 1);
      step();
      n++;
    end
    chk("hold_lat", n, 8);
    chk("hold_s", s, 32'h23456789);
    chk("hold_cout", cout, 0);
    // Still in DONE with start high: the next op is accepted with no IDLE cycle.
    a = 32'd1; b = 32'd1; sub = 1'b0;
    step();
    start = 1'b0;
    chk("b2b_busy", busy, 1);
    chk("b2b_done", done, 0);
    chk("b2b_s_clr", s, 0);
    n = 0; ndone = 0;
    while (!done && n < 20) begin
      step();
      n++;
    end
    chk("b2b_lat", n, 8);
    chk("b2b_s", s, 32'd2);
    step();

    // Reset mid-operation: outputs clear without a clock edge, no done follows.
    a = 32'h11111111; b = 32'h22222222; sub = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    chk("pre_rst_s", s, 32'h00000333);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_s", s, 0);
    chk("arst_cout", cout, 0);
    chk("arst_ovf", overflow, 0);
    step();
    reset = 1'b0;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      if (done) ndone++;
      step();
    end
    chk("abort_no_done", ndone, 0);
    op32("after_rst", 32'hDEADBEEF, 32'h01010101, 1'b0, 32'hDFAEBFF0, 1'b0, 1'b0);

    // 8-bit instance: two slice passes.
    a8 = 8'h7F; b8 = 8'h80; sub8 = 1'b1; start8 = 1'b1;
    step();
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 20) begin
      step();
      n++;
    end
    chk("w8_lat", n, 2);
    chk("w8_s", s8, 8'hFF);
    chk("w8_cout", cout8, 0);
    chk("w8_ovf", overflow8, 1);
    step();
    chk("w8_done_pulse", done8, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/add_nibble_seq.md
Name: add_nibble_seq

Overview:
Multi-cycle WIDTH-bit adder/subtractor. It reuses one 4-bit ripple slice across successive cycles, one nibble per cycle, least-significant nibble first, with a registered carry between nibbles. It trades latency for area in the ALU/address path and presents a start/busy/done handshake to the sequencing control logic.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of 4 and at least 8.
NIBBLES, WIDTH/4, number of slice passes; derived, never overridden.

Ports:
clk  input  1  single clock; all state changes on rising edge.
reset  input  1  asynchronous, active-high; clears all state immediately.
start  input  1  request; sampled only when the FSM is in IDLE or DONE.
sub  input  1  0 = a+b, 1 = a-b; sampled with start.
a  input  WIDTH  operand A; sampled with start.
b  input  WIDTH  operand B; sampled with start.
busy  output  1  high while nibbles are being processed.
done  output  1  one-cycle pulse; result valid.
s  output  WIDTH  sum/difference register.
cout  output  1  carry out of the MSB (for sub: 1 = no borrow).
overflow  output  1  two's-complement signed overflow.

Behaviour:
- Datapath:
  - One 4-bit slice built from four full_adder instances, with carry-in from the carry register.
  - Operand registers opa and opb; on sub, opb holds ~b and carry initialises to 1.
  - Nibble index counter, ceil(log2(NIBBLES)) bits wide.
- FSM states are IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - start=1 → latch a, b/~b, sub; carry ← sub; idx ← 0; s ← 0; go to RUN.
  - start=0 → stay in IDLE.
- RUN, each edge:
  - s[4*idx+3:4*idx] ← slice sum; carry ← slice cout; idx ← idx+1.
  - On the edge where idx = NIBBLES-1 → go to DONE; cout ← slice cout; overflow ← (opa[MSB] == opb[MSB]) && (sum MSB != opa[MSB]).
- DONE:
  - Lasts exactly one cycle, with done=1.
  - start=1 → accepted exactly as in IDLE (back-to-back operation, no bubble).
  - start=0 → go to IDLE.
- Timing, counting from the edge that samples start as edge 0:
  - busy=1 after edge 0 through edge NIBBLES.
  - done=1 for the cycle after edge NIBBLES.
  - Total latency is NIBBLES+1 edges (9 for WIDTH=32).
- Outputs:
  - busy and done are decoded from the state register (glitch-free, registered).
  - busy and done are never high together.
- Operand capture:
  - start while in RUN is ignored; there is no queuing.
  - a, b and sub changes during RUN have no effect; only the latched copies are used.
- Result hold:
  - s, cout and overflow hold their values from DONE until the next accepted start.
  - At an accepted start, s clears to 0 and cout/overflow clear to 0; s then fills nibble by nibble.
  - Intermediate s values during RUN are not valid and must not be consumed.
- Reset:
  - Asserting reset at any time, including mid-RUN, forces IDLE asynchronously.
  - Reset clears s, cout, overflow, busy, done, carry, idx and the operand registers to 0.
  - No done pulse is produced for an aborted operation.
- Width rules:
  - Arithmetic is modulo 2^WIDTH; cout is bit WIDTH of the extended result.
  - For sub, cout = 1 iff a >= b unsigned.

Test Plan:
- WIDTH=32, a=0xFFFFFFFF, b=0x00000001, sub=0 → s=0x00000000, cout=1, overflow=0; done exactly 9 edges after start; busy high for 8 cycles before it.
- a=0x7FFFFFFF, b=0x00000001, sub=0 → s=0x80000000, cout=0, overflow=1. Then a=0x80000000, b=0x80000000 → s=0, cout=1, overflow=1.
- a=5, b=7, sub=1 → s=0xFFFFFFFE, cout=0, overflow=0. Then a=7, b=5, sub=1 → s=0x00000002, cout=1.
- Start a=0x12345678, b=0x11111111; hold start high and change a/b every cycle during RUN → single done pulse, s=0x23456789, extra starts ignored. Start held through the DONE cycle with a=1, b=1 → second operation begins with no IDLE cycle; next done 9 edges later, s=2.
- Assert reset for one cycle at edge 4 of an operation → busy, done, s, cout and overflow go to 0 immediately without waiting for clk; no done pulse; next start computes correctly.
- WIDTH=8 instance, a=0x7F, b=0x80, sub=1 → s=0xFF, cout=0, overflow=1; done 3 edges after start.
